// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. one buffered MDU result.
// Optional starvation guard (counter + one-cycle FORCE stall) enabled by WB_ARB_STARVE_GUARD_EN.
module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_valid,
    input  logic [4:0]      pipe_wa,
    input  logic [XLEN-1:0] pipe_wd,
    output logic            pipe_ready,
    input  logic            mdu_valid,
    input  logic [4:0]      mdu_wa,
    input  logic [XLEN-1:0] mdu_wd,
    output logic            mdu_ready,
    output logic            pend_valid,
    output logic [4:0]      pend_wa,
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [XLEN-1:0] rf_wd,
    output logic            debug_RegWrite,
    output logic [4:0]      debug_WA,
    output logic [XLEN-1:0] debug_WB
);

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

`ifdef WB_ARB_STARVE_GUARD_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd1, ST_FORCE = 2'd2} state_t;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt_r;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd1} state_t;
`endif

    state_t          state_r;
    state_t          state_next_s;
    logic [4:0]      hold_wa_r;
    logic [XLEN-1:0] hold_wd_r;
    logic            hold_valid_s;
    logic            grant_pipe_s;
    logic            grant_hold_s;
    logic            pipe_ready_s;
    logic            mdu_ready_s;
    logic            mdu_accept_s;
    logic            rf_we_r;
    logic [4:0]      rf_wa_r;
    logic [XLEN-1:0] rf_wd_r;

    // The hold register is full in every state except IDLE.
    assign hold_valid_s = (state_r != ST_IDLE);
    assign mdu_ready_s  = rst_n && (!hold_valid_s || grant_hold_s);
    assign mdu_accept_s = mdu_valid && mdu_ready_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mdu_accept_s) state_next_s = ST_HOLD;
                else              state_next_s = ST_IDLE;
            end
            ST_HOLD: begin
                if (grant_hold_s) begin
                    if (mdu_accept_s) state_next_s = ST_HOLD;
                    else              state_next_s = ST_IDLE;
`ifdef WB_ARB_STARVE_GUARD_EN
                end else if (grant_pipe_s && starve_cnt_r == CNT_W'(STARVE_LIMIT - 1)) begin
                    state_next_s = ST_FORCE;
`endif
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
`ifdef WB_ARB_STARVE_GUARD_EN
            ST_FORCE: begin
                if (mdu_accept_s) state_next_s = ST_HOLD;
                else              state_next_s = ST_IDLE;
            end
`endif
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: per-cycle grant and pipeline handshake.
    always_comb begin
        grant_pipe_s = 1'b0;
        grant_hold_s = 1'b0;
        pipe_ready_s = 1'b0;
        if (!rst_n) begin
            pipe_ready_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    pipe_ready_s = 1'b1;
                    grant_pipe_s = pipe_valid;
                end
                ST_HOLD: begin
                    pipe_ready_s = 1'b1;
                    if (pipe_valid) grant_pipe_s = 1'b1;
                    else            grant_hold_s = 1'b1;
                end
`ifdef WB_ARB_STARVE_GUARD_EN
                ST_FORCE: begin
                    pipe_ready_s = 1'b0;
                    grant_hold_s = 1'b1;
                end
`endif
                default: begin
                    pipe_ready_s = 1'b0;
                    grant_pipe_s = 1'b0;
                    grant_hold_s = 1'b0;
                end
            endcase
        end
    end

`ifdef WB_ARB_STARVE_GUARD_EN
    // Starvation counter: counts pipe wins while a result waits, saturating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (grant_hold_s || state_next_s == ST_IDLE) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_HOLD && grant_pipe_s && starve_cnt_r != CNT_W'(STARVE_LIMIT)) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`endif

    // Hold register capture and registered write port; x0 writes are consumed silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we_r   <= 1'b0;
            rf_wa_r   <= 5'd0;
            rf_wd_r   <= {XLEN{1'b0}};
            hold_wa_r <= 5'd0;
            hold_wd_r <= {XLEN{1'b0}};
        end else begin
            if (grant_pipe_s) begin
                rf_we_r <= (pipe_wa != 5'd0);
                rf_wa_r <= pipe_wa;
                rf_wd_r <= pipe_wd;
            end else if (grant_hold_s) begin
                rf_we_r <= (hold_wa_r != 5'd0);
                rf_wa_r <= hold_wa_r;
                rf_wd_r <= hold_wd_r;
            end else begin
                rf_we_r <= 1'b0;
            end
            if (mdu_accept_s) begin
                hold_wa_r <= mdu_wa;
                hold_wd_r <= mdu_wd;
            end
        end
    end

    assign pipe_ready     = pipe_ready_s;
    assign mdu_ready      = mdu_ready_s;
    assign pend_valid     = hold_valid_s;
    assign pend_wa        = hold_wa_r;
    assign rf_we          = rf_we_r;
    assign rf_wa          = rf_wa_r;
    assign rf_wd          = rf_wd_r;
    assign debug_RegWrite = rf_we_r;
    assign debug_WA       = rf_wa_r;
    assign debug_WB       = rf_wd_r;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (default STARVE_LIMIT=4).
// Starvation expectations follow WB_ARB_STARVE_GUARD_EN when it is defined.
module tb_wb_port_arbiter;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            pipe_valid;
    logic [4:0]      pipe_wa;
    logic [XLEN-1:0] pipe_wd;
    logic            pipe_ready;
    logic            mdu_valid;
    logic [4:0]      mdu_wa;
    logic [XLEN-1:0] mdu_wd;
    logic            mdu_ready;
    logic            pend_valid;
    logic [4:0]      pend_wa;
    logic            rf_we;
    logic [4:0]      rf_wa;
    logic [XLEN-1:0] rf_wd;
    logic            debug_RegWrite;
    logic [4:0]      debug_WA;
    logic [XLEN-1:0] debug_WB;

    int tests = 0;
    int fails = 0;

    wb_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_valid(pipe_valid), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd), .pipe_ready(pipe_ready),
        .mdu_valid(mdu_valid), .mdu_wa(mdu_wa), .mdu_wd(mdu_wd), .mdu_ready(mdu_ready),
        .pend_valid(pend_valid), .pend_wa(pend_wa),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .debug_RegWrite(debug_RegWrite), .debug_WA(debug_WA), .debug_WB(debug_WB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_write(input string tag, input logic [4:0] wa, input logic [31:0] wd);
        chk({tag, "_we"}, rf_we, 32'd1);
        chk({tag, "_wa"}, rf_wa, wa);
        chk({tag, "_wd"}, rf_wd, wd);
    endtask

    initial begin
        // Reset with both requesters active
        rst_n = 1'b0;
        pipe_valid = 1'b1; pipe_wa = 5'd3; pipe_wd = 32'hDEAD_BEEF;
        mdu_valid  = 1'b1; mdu_wa  = 5'd4; mdu_wd  = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("rst_pipe_ready", pipe_ready, 32'd0);
            chk("rst_mdu_ready", mdu_ready, 32'd0);
            tick();
            chk("rst_rf_we", rf_we, 32'd0);
            chk("rst_rf_wd", rf_wd, 32'd0);
            chk("rst_pend_valid", pend_valid, 32'd0);
        end
        rst_n = 1'b1; pipe_valid = 1'b0; mdu_valid = 1'b0;
        settle();
        chk("idle_pipe_ready", pipe_ready, 32'd1);
        chk("idle_mdu_ready", mdu_ready, 32'd1);
        tick();

        // Lone MDU result
        mdu_valid = 1'b1; mdu_wa = 5'd5; mdu_wd = 32'h0000_1234;
        settle();
        chk("lone_mdu_ready", mdu_ready, 32'd1);
        tick();
        mdu_valid = 1'b0; mdu_wa = 5'd0; mdu_wd = 32'h0;
        settle();
        chk("lone_pend_valid", pend_valid, 32'd1);
        chk("lone_pend_wa", pend_wa, 32'd5);
        chk("lone_no_early_we", rf_we, 32'd0);
        tick();
        chk_write("lone", 5'd5, 32'h0000_1234);
        chk("lone_dbg_we", debug_RegWrite, 32'd1);
        chk("lone_dbg_wa", debug_WA, 32'd5);
        chk("lone_dbg_wb", debug_WB, 32'h0000_1234);
        chk("lone_pend_clr", pend_valid, 32'd0);
        tick();
        chk("lone_we_pulse", rf_we, 32'd0);

        // Collision: buffered x7 waits behind pipe writes x3, x4
        mdu_valid = 1'b1; mdu_wa = 5'd7; mdu_wd = 32'h0000_0077;
        tick();
        mdu_valid = 1'b0;
        pipe_valid = 1'b1; pipe_wa = 5'd3; pipe_wd = 32'h0000_000A;
        settle();
        chk("col_pipe_ready", pipe_ready, 32'd1);
        chk("col_mdu_ready", mdu_ready, 32'd0);
        tick();
        chk_write("col_x3", 5'd3, 32'h0000_000A);
        pipe_wa = 5'd4; pipe_wd = 32'h0000_000B;
        tick();
        chk_write("col_x4", 5'd4, 32'h0000_000B);
        chk("col_pend_still", pend_valid, 32'd1);
        pipe_valid = 1'b0;
        tick();
        chk_write("col_x7", 5'd7, 32'h0000_0077);
        chk("col_pend_clr", pend_valid, 32'd0);
        tick();

        // Starvation: pipe_valid held continuously with one buffered result
        pipe_valid = 1'b1; pipe_wa = 5'd2;
`ifdef WB_ARB_STARVE_GUARD_EN
        for (int i = 0; i < 5; i++) begin
            mdu_valid = (i == 0); mdu_wa = 5'd9; mdu_wd = 32'h0000_0099;
            pipe_wd = 32'h100 + i;
            settle();
            chk("stv_pipe_ready", pipe_ready, 32'd1);
            tick();
            chk_write("stv_pipe", 5'd2, 32'h100 + i);
        end
        mdu_valid = 1'b0;
        pipe_wd = 32'h105;
        settle();
        chk("stv_force_pipe_ready", pipe_ready, 32'd0);
        chk("stv_force_mdu_ready", mdu_ready, 32'd1);
        tick();
        chk_write("stv_mdu", 5'd9, 32'h0000_0099);
        settle();
        chk("stv_after_pipe_ready", pipe_ready, 32'd1);
        tick();
        chk_write("stv_pipe_resume", 5'd2, 32'h105);
`else
        for (int i = 0; i < 6; i++) begin
            mdu_valid = (i == 0); mdu_wa = 5'd9; mdu_wd = 32'h0000_0099;
            pipe_wd = 32'h100 + i;
            settle();
            chk("stv_pipe_ready", pipe_ready, 32'd1);
            tick();
            chk_write("stv_pipe", 5'd2, 32'h100 + i);
            chk("stv_pend", pend_valid, 32'd1);
        end
        mdu_valid = 1'b0;
        pipe_valid = 1'b0;
        tick();
        chk_write("stv_mdu", 5'd9, 32'h0000_0099);
`endif
        pipe_valid = 1'b0; mdu_valid = 1'b0;
        tick();
        chk("stv_pend_clr", pend_valid, 32'd0);

        // x0 suppression, then buffered MDU write to x1
        pipe_valid = 1'b1; pipe_wa = 5'd0; pipe_wd = 32'hFFFF_FFFF;
        mdu_valid = 1'b1; mdu_wa = 5'd1; mdu_wd = 32'h0000_0011;
        settle();
        chk("x0_pipe_ready", pipe_ready, 32'd1);
        tick();
        pipe_valid = 1'b0; mdu_valid = 1'b0;
        chk("x0_we_low", rf_we, 32'd0);
        tick();
        chk_write("x0_then_x1", 5'd1, 32'h0000_0011);

        // Back-to-back MDU results
        for (int i = 0; i < 3; i++) begin
            mdu_valid = 1'b1; mdu_wa = 5'd10 + 5'(i); mdu_wd = 32'hA1 + i;
            settle();
            chk("b2b_mdu_ready", mdu_ready, 32'd1);
            tick();
            if (i == 0) chk("b2b_first_we", rf_we, 32'd0);
            else        chk_write("b2b", 5'd9 + 5'(i), 32'hA0 + i);
        end
        mdu_valid = 1'b0;
        tick();
        chk_write("b2b_last", 5'd12, 32'hA3);
        tick();
        chk("b2b_we_end", rf_we, 32'd0);
        chk("b2b_pend_end", pend_valid, 32'd0);

        // Reset mid-operation drops the buffered result
        mdu_valid = 1'b1; mdu_wa = 5'd6; mdu_wd = 32'h0000_0066;
        tick();
        mdu_valid = 1'b0;
        rst_n = 1'b0;
        settle();
        chk("mid_rst_mdu_ready", mdu_ready, 32'd0);
        chk("mid_rst_pipe_ready", pipe_ready, 32'd0);
        tick();
        rst_n = 1'b1;
        settle();
        chk("mid_rst_pend", pend_valid, 32'd0);
        chk("mid_rst_we", rf_we, 32'd0);
        tick();
        chk("mid_rst_no_write", rf_we, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
